// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the pipeline MEM stage and an
//   external (debug / program-loader) requester. The pipeline normally wins.
//   A saturating starvation counter forces one external slot after
//   STARVE_LIMIT consecutive pipeline wins while the external port waits.
//   The synchronous DMEM read word is routed back to whichever side issued
//   the read on the previous cycle.
//
// Ports
//   clock, reset          sole clock; synchronous active-high reset
//   in_pipe_load/store    pipeline request (store wins if both are set)
//   in_pipe_addr          pipeline address
//   in_pipe_wr_word       pipeline store data
//   out_pipe_stall        pipeline lost arbitration this cycle
//   out_pipe_rd_word      pipeline load data, cycle after a granted load
//   in_ext_req/we         external request / write-not-read, held until ack
//   in_ext_addr           external address
//   in_ext_wr_word        external write data
//   out_ext_ack           external request granted this cycle
//   out_ext_rd_valid      external read data valid
//   out_ext_rd_word       external read data
//   out_mem_addr          DMEM address
//   out_mem_wr_word       DMEM write data
//   out_mem_write_en      DMEM write enable
//   in_mem_rd_word        DMEM read data, one cycle after the address

module dmem_arbiter #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int STARVE_LIMIT    = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_pipe_load,
    input  logic                       in_pipe_store,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_pipe_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_pipe_wr_word,
    output logic                       out_pipe_stall,
    output logic [DMEM_WORD_WIDTH-1:0] out_pipe_rd_word,
    input  logic                       in_ext_req,
    input  logic                       in_ext_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_ext_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_ext_wr_word,
    output logic                       out_ext_ack,
    output logic                       out_ext_rd_valid,
    output logic [DMEM_WORD_WIDTH-1:0] out_ext_rd_word,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
    output logic                       out_mem_write_en,
    input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word
);

    localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

    logic                 pipe_req;
    logic                 grant_ext;
    logic                 grant_pipe;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 pipe_rd_pend;
    logic                 ext_rd_pend;

    // Grants are suppressed during reset so every DMEM-facing and
    // requester-facing output reads as idle while reset is held.
    always_comb begin
        pipe_req   = in_pipe_load | in_pipe_store;
        grant_ext  = !reset && in_ext_req && (!pipe_req || cnt == STARVE_MAX);
        grant_pipe = !reset && pipe_req && !grant_ext;
    end

    always_comb begin
        out_mem_addr     = '0;
        out_mem_wr_word  = '0;
        out_mem_write_en = 1'b0;
        if (grant_ext) begin
            out_mem_addr     = in_ext_addr;
            out_mem_wr_word  = in_ext_wr_word;
            out_mem_write_en = in_ext_we;
        end else if (grant_pipe) begin
            out_mem_addr     = in_pipe_addr;
            out_mem_wr_word  = in_pipe_wr_word;
            out_mem_write_en = in_pipe_store;
        end
    end

    // Pending flags are still live during the reset cycle, so the read-data
    // outputs are gated by reset to drop an in-flight read immediately.
    always_comb begin
        out_ext_ack      = grant_ext;
        out_pipe_stall   = pipe_req && grant_ext;
        out_pipe_rd_word = (pipe_rd_pend && !reset) ? in_mem_rd_word : '0;
        out_ext_rd_valid = ext_rd_pend && !reset;
        out_ext_rd_word  = (ext_rd_pend && !reset) ? in_mem_rd_word : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt          <= '0;
            pipe_rd_pend <= 1'b0;
            ext_rd_pend  <= 1'b0;
        end else begin
            if (grant_ext || !in_ext_req) begin
                cnt <= '0;
            end else if (grant_pipe && cnt != STARVE_MAX) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
            // A combined load+store is treated as a store: no read return.
            pipe_rd_pend <= grant_pipe && in_pipe_load && !in_pipe_store;
            ext_rd_pend  <= grant_ext && !in_ext_we;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        in_pipe_load;
    logic        in_pipe_store;
    logic [11:0] in_pipe_addr;
    logic [15:0] in_pipe_wr_word;
    logic        out_pipe_stall;
    logic [15:0] out_pipe_rd_word;
    logic        in_ext_req;
    logic        in_ext_we;
    logic [11:0] in_ext_addr;
    logic [15:0] in_ext_wr_word;
    logic        out_ext_ack;
    logic        out_ext_rd_valid;
    logic [15:0] out_ext_rd_word;
    logic [11:0] out_mem_addr;
    logic [15:0] out_mem_wr_word;
    logic        out_mem_write_en;
    logic [15:0] in_mem_rd_word;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(
        .DMEM_ADDR_WIDTH(12),
        .DMEM_WORD_WIDTH(16),
        .STARVE_LIMIT   (4),
        .CNT_WIDTH      (3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_pipe_load    (in_pipe_load),
        .in_pipe_store   (in_pipe_store),
        .in_pipe_addr    (in_pipe_addr),
        .in_pipe_wr_word (in_pipe_wr_word),
        .out_pipe_stall  (out_pipe_stall),
        .out_pipe_rd_word(out_pipe_rd_word),
        .in_ext_req      (in_ext_req),
        .in_ext_we       (in_ext_we),
        .in_ext_addr     (in_ext_addr),
        .in_ext_wr_word  (in_ext_wr_word),
        .out_ext_ack     (out_ext_ack),
        .out_ext_rd_valid(out_ext_rd_valid),
        .out_ext_rd_word (out_ext_rd_word),
        .out_mem_addr    (out_mem_addr),
        .out_mem_wr_word (out_mem_wr_word),
        .out_mem_write_en(out_mem_write_en),
        .in_mem_rd_word  (in_mem_rd_word)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port DMEM, one-cycle read latency.
    logic [15:0] mem [0:4095];
    always @(posedge clock) begin
        if (out_mem_write_en) mem[out_mem_addr] <= out_mem_wr_word;
        in_mem_rd_word <= mem[out_mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pipe(input logic ld, input logic st, input logic [11:0] a, input logic [15:0] d);
        in_pipe_load    = ld;
        in_pipe_store   = st;
        in_pipe_addr    = a;
        in_pipe_wr_word = d;
    endtask

    task automatic ext(input logic rq, input logic we, input logic [11:0] a, input logic [15:0] d);
        in_ext_req     = rq;
        in_ext_we      = we;
        in_ext_addr    = a;
        in_ext_wr_word = d;
    endtask

    initial begin
        reset = 1'b1;
        pipe(1'b1, 1'b1, 12'h123, 16'hFFFF);
        ext(1'b1, 1'b1, 12'h456, 16'hEEEE);
        settle();
        chk("rst_ack", out_ext_ack, 0);
        chk("rst_stall", out_pipe_stall, 0);
        chk("rst_we", out_mem_write_en, 0);
        chk("rst_addr", out_mem_addr, 0);
        chk("rst_wdata", out_mem_wr_word, 0);
        tick();
        chk("rst_cnt", dut.cnt, 0);
        chk("rst_ext_valid", out_ext_rd_valid, 0);
        chk("rst_pipe_rd", out_pipe_rd_word, 0);
        reset = 1'b0;
        pipe(1'b0, 1'b0, 12'h0, 16'h0);
        ext(1'b0, 1'b0, 12'h0, 16'h0);
        settle();
        chk("idle_addr", out_mem_addr, 0);
        chk("idle_we", out_mem_write_en, 0);

        // Pipeline only: store then load.
        tick();
        pipe(1'b0, 1'b1, 12'h010, 16'hBEEF);
        settle();
        chk("p_store_we", out_mem_write_en, 1);
        chk("p_store_addr", out_mem_addr, 12'h010);
        chk("p_store_data", out_mem_wr_word, 16'hBEEF);
        chk("p_store_stall", out_pipe_stall, 0);
        chk("p_store_ack", out_ext_ack, 0);
        tick();
        pipe(1'b1, 1'b0, 12'h010, 16'h0);
        settle();
        chk("p_load_we", out_mem_write_en, 0);
        chk("p_load_addr", out_mem_addr, 12'h010);
        tick();
        pipe(1'b0, 1'b0, 12'h0, 16'h0);
        settle();
        chk("p_load_data", out_pipe_rd_word, 16'hBEEF);
        chk("p_load_no_ext", out_ext_rd_valid, 0);

        // External only: write then read.
        tick();
        ext(1'b1, 1'b1, 12'h0FF, 16'h1234);
        settle();
        chk("e_wr_ack", out_ext_ack, 1);
        chk("e_wr_we", out_mem_write_en, 1);
        chk("e_wr_addr", out_mem_addr, 12'h0FF);
        chk("e_wr_data", out_mem_wr_word, 16'h1234);
        tick();
        ext(1'b1, 1'b0, 12'h0FF, 16'h0);
        settle();
        chk("e_rd_ack", out_ext_ack, 1);
        chk("e_rd_we", out_mem_write_en, 0);
        chk("e_rd_valid_early", out_ext_rd_valid, 0);
        tick();
        ext(1'b0, 1'b0, 12'h0, 16'h0);
        settle();
        chk("e_rd_valid", out_ext_rd_valid, 1);
        chk("e_rd_data", out_ext_rd_word, 16'h1234);
        chk("e_rd_no_pipe", out_pipe_rd_word, 0);
        tick();
        settle();
        chk("e_rd_valid_drop", out_ext_rd_valid, 0);

        // Preload words used by the routing test.
        pipe(1'b0, 1'b1, 12'h020, 16'hAAAA);
        tick();
        pipe(1'b0, 1'b1, 12'h021, 16'h5555);
        tick();

        // Starvation: pipeline loads every cycle, external read held.
        pipe(1'b1, 1'b0, 12'h010, 16'h0);
        ext(1'b1, 1'b0, 12'h020, 16'h0);
        for (int i = 1; i <= 4; i++) begin
            settle();
            chk($sformatf("starve_ack_c%0d", i), out_ext_ack, 0);
            chk($sformatf("starve_stall_c%0d", i), out_pipe_stall, 0);
            chk($sformatf("starve_addr_c%0d", i), out_mem_addr, 12'h010);
            tick();
        end
        settle();
        chk("starve_cnt_sat", dut.cnt, 4);
        chk("starve_ack_c5", out_ext_ack, 1);
        chk("starve_stall_c5", out_pipe_stall, 1);
        chk("starve_addr_c5", out_mem_addr, 12'h020);
        chk("starve_pipe_rd_c5", out_pipe_rd_word, 16'hBEEF);
        tick();
        ext(1'b0, 1'b0, 12'h0, 16'h0);
        settle();
        chk("starve_cnt_clr", dut.cnt, 0);
        chk("starve_ack_c6", out_ext_ack, 0);
        chk("starve_stall_c6", out_pipe_stall, 0);
        chk("starve_addr_c6", out_mem_addr, 12'h010);
        chk("starve_ext_valid_c6", out_ext_rd_valid, 1);
        chk("starve_ext_data_c6", out_ext_rd_word, 16'hAAAA);
        chk("starve_pipe_rd_c6", out_pipe_rd_word, 0);
        tick();
        pipe(1'b0, 1'b0, 12'h0, 16'h0);
        settle();
        chk("starve_pipe_rd_c7", out_pipe_rd_word, 16'hBEEF);
        chk("starve_ext_valid_c7", out_ext_rd_valid, 0);
        tick();

        // Read routing: ext read then pipeline load back to back.
        ext(1'b1, 1'b0, 12'h020, 16'h0);
        settle();
        chk("route_ack", out_ext_ack, 1);
        tick();
        ext(1'b0, 1'b0, 12'h0, 16'h0);
        pipe(1'b1, 1'b0, 12'h021, 16'h0);
        settle();
        chk("route_c2_stall", out_pipe_stall, 0);
        chk("route_c2_ext_valid", out_ext_rd_valid, 1);
        chk("route_c2_ext_data", out_ext_rd_word, 16'hAAAA);
        chk("route_c2_pipe_data", out_pipe_rd_word, 0);
        tick();
        pipe(1'b0, 1'b0, 12'h0, 16'h0);
        settle();
        chk("route_c3_pipe_data", out_pipe_rd_word, 16'h5555);
        chk("route_c3_ext_valid", out_ext_rd_valid, 0);
        chk("route_c3_ext_data", out_ext_rd_word, 0);
        tick();
        settle();
        chk("route_c4_pipe_data", out_pipe_rd_word, 0);

        // Load+store conflict: store wins, no read return.
        pipe(1'b1, 1'b1, 12'h030, 16'h0F0F);
        settle();
        chk("conf_we", out_mem_write_en, 1);
        chk("conf_addr", out_mem_addr, 12'h030);
        chk("conf_data", out_mem_wr_word, 16'h0F0F);
        tick();
        pipe(1'b1, 1'b0, 12'h030, 16'h0);
        settle();
        chk("conf_pend", dut.pipe_rd_pend, 0);
        chk("conf_rd_zero", out_pipe_rd_word, 0);
        tick();
        pipe(1'b0, 1'b0, 12'h0, 16'h0);
        settle();
        chk("conf_written", out_pipe_rd_word, 16'h0F0F);
        tick();

        // Reset during an in-flight external read.
        ext(1'b1, 1'b0, 12'h0FF, 16'h0);
        settle();
        chk("rmid_ack", out_ext_ack, 1);
        tick();
        reset = 1'b1;
        pipe(1'b1, 1'b0, 12'h010, 16'h0);
        settle();
        chk("rmid_valid", out_ext_rd_valid, 0);
        chk("rmid_ext_data", out_ext_rd_word, 0);
        chk("rmid_pipe_data", out_pipe_rd_word, 0);
        chk("rmid_ack_low", out_ext_ack, 0);
        chk("rmid_stall_low", out_pipe_stall, 0);
        chk("rmid_addr", out_mem_addr, 0);
        tick();
        reset = 1'b0;
        pipe(1'b0, 1'b0, 12'h0, 16'h0);
        ext(1'b0, 1'b0, 12'h0, 16'h0);
        settle();
        chk("rmid_cnt", dut.cnt, 0);
        chk("rmid_valid_after", out_ext_rd_valid, 0);
        tick();
        ext(1'b1, 1'b0, 12'h0FF, 16'h0);
        settle();
        chk("rmid_first_ack", out_ext_ack, 1);
        tick();
        ext(1'b0, 1'b0, 12'h0, 16'h0);
        settle();
        chk("rmid_rd_valid", out_ext_rd_valid, 1);
        chk("rmid_rd_data", out_ext_rd_word, 16'h1234);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
